// File: rtl/serial_byte_rx.sv
// serial_byte_rx: front-end receiver for the external serial link.
// Synchronizes serial_clk/serial_data/serial_en into clk_50, hunts for the
// header byte bit-by-bit, then deserializes PAYLOAD_BYTES MSB-first bytes.
// Each completed byte produces a one-cycle byte_complete pulse; header_flag
// marks the header. Dropping serial_en inside a packet raises framing_err.
module serial_byte_rx #(
    parameter logic [7:0] HEADER_BYTE   = 8'hA5,
    parameter int         PAYLOAD_BYTES = 4
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       serial_clk,
    input  logic       serial_data,
    input  logic       serial_en,
    output logic [7:0] byte_out,
    output logic       byte_complete,
    output logic       header_flag,
    output logic       framing_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        ALIGNED = 2'd2
    } state_t;

    localparam logic [3:0] PAY_LAST = 4'(PAYLOAD_BYTES);

    // Synchronizer chain, bit order {clk, data, en}; clock and data share
    // the same depth so the sampled data lines up with the detected edge.
    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic       sclk_prev_q, sclk_prev_d;

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [3:0] hunt_cnt_q, hunt_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] pay_cnt_q, pay_cnt_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_complete_q, byte_complete_d;
    logic       header_flag_q, header_flag_d;
    logic       framing_err_q, framing_err_d;

    logic sclk_s, data_s, en_s, sclk_rise;

    assign sclk_s    = sync_q[2];
    assign data_s    = sync_q[1];
    assign en_s      = sync_q[0];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // Next values of the synchronizer and edge-detect flops.
    always_comb begin
        meta_d      = {serial_clk, serial_data, serial_en};
        sync_d      = meta_q;
        sclk_prev_d = sclk_s;
    end

    // Synchronizer and edge-detect registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            meta_q      <= '0;
            sync_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    // Receiver FSM: next state, shift/counter updates and registered outputs.
    // Losing enable takes priority over a coincident bit-clock edge.
    always_comb begin
        state_d         = state_q;
        sr_d            = sr_q;
        hunt_cnt_d      = hunt_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        pay_cnt_d       = pay_cnt_q;
        byte_out_d      = byte_out_q;
        byte_complete_d = 1'b0;
        header_flag_d   = 1'b0;
        framing_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_s) begin
                    state_d    = HUNT;
                    sr_d       = '0;
                    hunt_cnt_d = '0;
                end
            end
            HUNT: begin
                if (!en_s) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    sr_d = {sr_q[6:0], data_s};
                    if (hunt_cnt_q != 4'd8) begin
                        hunt_cnt_d = hunt_cnt_q + 4'd1;
                    end
                    // Only a window of 8 freshly sampled bits may match.
                    if (hunt_cnt_d == 4'd8 && sr_d == HEADER_BYTE) begin
                        byte_out_d      = HEADER_BYTE;
                        byte_complete_d = 1'b1;
                        header_flag_d   = 1'b1;
                        bit_cnt_d       = '0;
                        pay_cnt_d       = '0;
                        state_d         = ALIGNED;
                    end
                end
            end
            ALIGNED: begin
                if (!en_s) begin
                    framing_err_d = 1'b1;
                    state_d       = IDLE;
                end else if (sclk_rise) begin
                    sr_d      = {sr_q[6:0], data_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_out_d      = sr_d;
                        byte_complete_d = 1'b1;
                        pay_cnt_d       = pay_cnt_q + 4'd1;
                        if (pay_cnt_d == PAY_LAST) begin
                            state_d    = HUNT;
                            hunt_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, datapath and output registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            sr_q            <= '0;
            hunt_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            pay_cnt_q       <= '0;
            byte_out_q      <= '0;
            byte_complete_q <= 1'b0;
            header_flag_q   <= 1'b0;
            framing_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            sr_q            <= sr_d;
            hunt_cnt_q      <= hunt_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            pay_cnt_q       <= pay_cnt_d;
            byte_out_q      <= byte_out_d;
            byte_complete_q <= byte_complete_d;
            header_flag_q   <= header_flag_d;
            framing_err_q   <= framing_err_d;
        end
    end

    assign byte_out      = byte_out_q;
    assign byte_complete = byte_complete_q;
    assign header_flag   = header_flag_q;
    assign framing_err   = framing_err_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: drives bit streams on the serial pins and checks every
// clk_50 cycle against a stream-level model: header positions are found by
// scanning the whole bit stream for the header pattern, payload bytes are
// the following 8-bit groups, and each expected pulse is due 3 cycles after
// the pin edge of its last bit.
`timescale 1ns/1ps
module tb_serial_byte_rx;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int         PAY = 4;

    logic       clk_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_clk = 1'b0;
    logic       serial_data = 1'b0;
    logic       serial_en = 1'b0;
    logic [7:0] byte_out;
    logic       byte_complete;
    logic       header_flag;
    logic       framing_err;

    serial_byte_rx #(.HEADER_BYTE(HDR), .PAYLOAD_BYTES(PAY)) dut (
        .clk_50       (clk_50),
        .reset_n      (reset_n),
        .serial_clk   (serial_clk),
        .serial_data  (serial_data),
        .serial_en    (serial_en),
        .byte_out     (byte_out),
        .byte_complete(byte_complete),
        .header_flag  (header_flag),
        .framing_err  (framing_err)
    );

    // Clock and cycle counter.
    always #10 clk_50 = ~clk_50;
    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard state.
    logic [8:0] exp_q[$];      // {header_flag, byte}
    int         due_q[$];      // cycle in which the pulse is due
    int         fe_due_q[$];   // cycles in which framing_err is due
    logic [7:0] last_byte = 8'h00;
    logic [8:0] got_q[$];
    logic [8:0] lit_q[$];
    int         fe_cnt = 0;

    // Stimulus stream and the per-bit expected events derived from it.
    bit         bits_q[$];
    bit         ev_v[0:1023];
    logic [8:0] ev_d[0:1023];
    bit         rnd_phase = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] byte_at(input int j);
        logic [7:0] v;
        v = 8'h00;
        for (int t = 0; t < 8; t++) v = {v[6:0], 1'(bits_q[j - 7 + t])};
        return v;
    endfunction

    // Scan the stream: find the first header window of 8 bits at or after the
    // hunt start, take up to PAY bytes after it, resume hunting after the
    // packet. Returns 1 if the stream ends inside a packet.
    function automatic bit plan();
        int n, s, e;
        bit done, open;
        n = bits_q.size();
        s = 0;
        done = 1'b0;
        open = 1'b0;
        for (int i = 0; i < 1024; i++) ev_v[i] = 1'b0;
        while (!done) begin
            e = -1;
            for (int j = s + 7; j < n && e < 0; j++) if (byte_at(j) == HDR) e = j;
            if (e < 0) begin
                done = 1'b1;
            end else begin
                ev_v[e] = 1'b1;
                ev_d[e] = {1'b1, HDR};
                for (int k = 1; k <= PAY; k++) begin
                    if (e + 8 * k < n) begin
                        ev_v[e + 8 * k] = 1'b1;
                        ev_d[e + 8 * k] = {1'b0, byte_at(e + 8 * k)};
                    end else begin
                        open = 1'b1;
                    end
                end
                if (open) done = 1'b1;
                s = e + 8 * PAY + 1;
            end
        end
        return open;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bits_q.push_back(b[i]);
    endtask

    // Driver: data changes with the falling phase, sampled on the rising edge.
    task automatic send_bit(input int idx);
        int lo, hi;
        lo = rnd_phase ? 10 * $urandom_range(5, 8) : 50;
        hi = rnd_phase ? 10 * $urandom_range(5, 8) : 50;
        serial_data = bits_q[idx];
        serial_clk  = 1'b0;
        #(lo);
        serial_clk = 1'b1;
        if (ev_v[idx]) begin
            due_q.push_back(cyc + 3);
            exp_q.push_back(ev_d[idx]);
        end
        #(hi);
    endtask

    task automatic run_frame();
        bit open;
        open = plan();
        @(posedge clk_50);
        #3;
        serial_en = 1'b1;
        #100;
        for (int i = 0; i < bits_q.size(); i++) send_bit(i);
        #100;
        serial_en = 1'b0;
        if (open) fe_due_q.push_back(cyc + 3);
        #200;
        bits_q.delete();
    endtask

    task automatic check_got(input string nm);
        chk({nm, "_count"}, got_q.size(), lit_q.size());
        for (int i = 0; i < got_q.size() && i < lit_q.size(); i++)
            chk(nm, 32'(got_q[i]), 32'(lit_q[i]));
        got_q.delete();
    endtask

    // Compare process: every cycle, outputs against the scoreboard.
    always @(negedge clk_50) begin
        logic       exp_bc, exp_fe;
        logic [8:0] e;
        exp_bc = (due_q.size() != 0) && (due_q[0] == cyc);
        exp_fe = (fe_due_q.size() != 0) && (fe_due_q[0] == cyc);
        e = exp_bc ? exp_q[0] : 9'h000;
        if (exp_bc) begin
            last_byte = e[7:0];
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
        end
        if (exp_fe) void'(fe_due_q.pop_front());
        chk("byte_complete", 32'(byte_complete), 32'(exp_bc));
        chk("header_flag", 32'(header_flag), 32'(exp_bc & e[8]));
        chk("byte_out", 32'(byte_out), 32'(last_byte));
        chk("framing_err", 32'(framing_err), 32'(exp_fe));
        if (byte_complete) got_q.push_back({header_flag, byte_out});
        if (framing_err) fe_cnt++;
    end

    initial begin
        int nj, nb;
        // Reset values.
        repeat (3) @(posedge clk_50);
        #1;
        chk("rst_byte_out", 32'(byte_out), 32'h0);
        chk("rst_byte_complete", 32'(byte_complete), 32'h0);
        chk("rst_header_flag", 32'(header_flag), 32'h0);
        chk("rst_framing_err", 32'(framing_err), 32'h0);
        @(negedge clk_50);
        reset_n = 1'b1;
        repeat (5) @(posedge clk_50);

        // 1: plain packet.
        push_byte(8'hA5); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        run_frame();
        lit_q = {9'h1A5, 9'h011, 9'h022, 9'h033, 9'h044};
        check_got("pkt_basic");

        // 2: junk bits before the header.
        bits_q.push_back(1'b1); bits_q.push_back(1'b0); bits_q.push_back(1'b1);
        push_byte(8'hA5); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        run_frame();
        lit_q = {9'h1A5, 9'h011, 9'h022, 9'h033, 9'h044};
        check_got("pkt_junk");

        // 3: full packet, non-header byte, second packet.
        push_byte(8'hA5); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        push_byte(8'h5A);
        push_byte(8'hA5); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
        run_frame();
        lit_q = {9'h1A5, 9'h011, 9'h022, 9'h033, 9'h044,
                 9'h1A5, 9'h001, 9'h002, 9'h003, 9'h004};
        check_got("pkt_rehunt");

        // 4: header value inside the payload.
        for (int i = 0; i < 5; i++) push_byte(8'hA5);
        run_frame();
        lit_q = {9'h1A5, 9'h0A5, 9'h0A5, 9'h0A5, 9'h0A5};
        check_got("pkt_all_a5");

        // 5: enable dropped 3 bits into payload byte 2, then a clean packet.
        fe_cnt = 0;
        push_byte(8'hA5); push_byte(8'h11);
        bits_q.push_back(1'b0); bits_q.push_back(1'b0); bits_q.push_back(1'b1);
        run_frame();
        lit_q = {9'h1A5, 9'h011};
        check_got("pkt_abort");
        chk("abort_fe_count", 32'(fe_cnt), 32'd1);
        push_byte(8'hA5); push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
        run_frame();
        lit_q = {9'h1A5, 9'h0DE, 9'h0AD, 9'h0BE, 9'h0EF};
        check_got("pkt_after_abort");

        // Randomized frames: junk, bytes (often the header), random tails.
        rnd_phase = 1'b1;
        for (int f = 0; f < 25; f++) begin
            nj = $urandom_range(0, 10);
            for (int i = 0; i < nj; i++) bits_q.push_back(1'($urandom_range(0, 1)));
            nb = $urandom_range(0, 12);
            for (int i = 0; i < nb; i++)
                push_byte(($urandom_range(0, 2) == 0) ? HDR : 8'($urandom));
            nj = $urandom_range(0, 7);
            for (int i = 0; i < nj; i++) bits_q.push_back(1'($urandom_range(0, 1)));
            run_frame();
        end
        rnd_phase = 1'b0;
        got_q.delete();

        // 6: asynchronous reset in the middle of a byte.
        push_byte(8'hA5); push_byte(8'h5A);
        run_frame();
        got_q.delete();
        for (int i = 0; i < 4; i++) bits_q.push_back(1'b1);
        void'(plan());
        @(posedge clk_50);
        #3;
        serial_en = 1'b1;
        #100;
        for (int i = 0; i < 4; i++) send_bit(i);
        bits_q.delete();
        #5;
        chk("pre_reset_byte_out", 32'(byte_out), 32'h5A);
        reset_n   = 1'b0;
        last_byte = 8'h00;
        #1;
        chk("async_byte_out", 32'(byte_out), 32'h0);
        chk("async_byte_complete", 32'(byte_complete), 32'h0);
        chk("async_header_flag", 32'(header_flag), 32'h0);
        chk("async_framing_err", 32'(framing_err), 32'h0);
        serial_en  = 1'b0;
        serial_clk = 1'b0;
        #100;
        @(negedge clk_50);
        reset_n = 1'b1;
        repeat (50) @(posedge clk_50);
        lit_q.delete();
        check_got("post_reset_quiet");

        chk("pending_bytes", 32'(due_q.size()), 32'd0);
        chk("pending_framing", 32'(fe_due_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_byte_rx.md
Name: serial_byte_rx

Overview:
Front-end serial receiver in the clk_50 domain, directly upstream of the packet input FSM. It synchronizes an external serial link (serial_clk, serial_data, serial_en), hunts for the header byte, and deserializes MSB-first bytes. For each byte it emits a one-cycle byte_complete pulse, with header_flag marking the header byte. Packet format is one header byte followed by PAYLOAD_BYTES payload bytes, matching the downstream byte-count FSM.

Parameters:
HEADER_BYTE, 8'hA5, byte pattern that starts a packet
PAYLOAD_BYTES, 4, number of payload bytes after each header (1..15)

Ports:
clk_50  input  1  50 MHz system clock
reset_n  input  1  asynchronous active-low reset
serial_clk  input  1  async serial bit clock; data is valid on its rising edge
serial_data  input  1  async serial data, MSB first
serial_en  input  1  async frame enable, active high
byte_out  output  8  last received byte; held until the next byte_complete
byte_complete  output  1  one-cycle pulse; byte_out is valid in the same cycle
header_flag  output  1  high only together with byte_complete when the byte is the packet header
framing_err  output  1  one-cycle pulse when serial_en drops mid-packet

Behaviour:
- Reset: reset_n is asynchronous, active-low; clk_50 is the only clock. Reset clears all sync flops, the shift register and all counters. byte_out=0, byte_complete=0, header_flag=0, framing_err=0. State=IDLE.
- Synchronization: 2-flop synchronizer on each of serial_clk, serial_data and serial_en. A third flop on synced serial_clk provides rising-edge detect.
- Link constraint: serial_clk high and low phases must each be at least 2 clk_50 cycles (40 ns), giving a maximum link rate of 12.5 MHz. Faster links are unsupported and no detection is required.
- A bit is sampled in the cycle the synced serial_clk edge is detected, using synced serial_data. Data and clock share equal sync depth.
- All outputs are registered. Latency from the detect cycle to the output pulse is 1 clk_50 cycle; pin-to-pulse latency is 3 clk_50 cycles.
- State machine:
  - IDLE: waits for synced serial_en=1, then goes to HUNT with the shift register and hunt_cnt cleared.
  - HUNT: each sampled bit shifts in (sr <= {sr[6:0],bit}) and hunt_cnt saturates at 8. When hunt_cnt>=8 and the new sr equals HEADER_BYTE: byte_out=HEADER_BYTE, byte_complete=1, header_flag=1, bit_cnt=0, pay_cnt=0, go to ALIGNED. No other pulses are issued in HUNT.
  - ALIGNED: bit_cnt counts 0..7. On the 8th bit: byte_out=sr, byte_complete=1, header_flag=0, pay_cnt increments. When pay_cnt reaches PAYLOAD_BYTES, go to HUNT with hunt_cnt=0 (8 fresh bits required). A payload byte equal to HEADER_BYTE is treated as data.
- serial_en deassert (synced value 0):
  - In ALIGNED: framing_err=1 for one cycle, partial byte discarded, no byte_complete, go to IDLE.
  - In HUNT: go to IDLE silently.
  - If en=0 in the same cycle as a clk edge detect, the enable check wins: the edge is ignored and the abort path is taken.
- byte_complete pulses are at least 16 clk_50 cycles apart, so back-to-back pulses never occur.
- Reset mid-operation forces the reset values above immediately; any partial packet is lost.

Test Plan:
1. Reset, serial_en=1, send A5 11 22 33 44 at 10 MHz -> exactly 5 byte_complete pulses. byte_out sequence is A5,11,22,33,44. header_flag=1 only on the first pulse. Each pulse is 3 clk_50 cycles after the 8th-bit pin edge.
2. Send junk bits 1,0,1 then A5 11 22 33 44 -> no pulses during the junk. Header is detected on the 8th bit of A5, and the payload is received correctly aligned.
3. After a full packet, send 5A then A5 01 02 03 04 -> no pulse for 5A. The next packet is received with header_flag=1 on A5.
4. Packet A5 A5 A5 A5 A5 -> 5 pulses. header_flag=1 on the first only; the payload A5 bytes have header_flag=0.
5. Drop serial_en after 3 bits of payload byte 2 -> framing_err pulses for exactly 1 cycle, with no byte_complete for the partial byte. Re-enable and send A5 DE AD BE EF -> normal reception.
6. Assert reset_n=0 mid-byte between clk_50 edges -> all outputs go to 0 asynchronously. After release with no stimulus, no pulses occur.
